aec_expr_tx: RTL and testbench
==============================

Name: aec_expr_tx

Overview:
- Hardware driver for the AEC ascii-stream interface.
- Buffers an ASCII expression written byte-by-byte and serialises it to AEC, one character per clock; the first character is marked by a one-cycle ready pulse.
- Then waits for AEC valid, captures the 7-bit result and reports done or timeout.
- Sits between a host or config bus and the AEC instance. Used in on-chip self-test and in system bring-up.

Parameters:
- DEPTH, 16: maximum buffered characters, including '='.
- TIMEOUT, 64: cycles to wait for valid_i after the last character before aborting.
- CW, $clog2(DEPTH+1): width of the character count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  append wr_data to buffer
- wr_data  in  8  ASCII character to append
- buf_full  out  1  buffer holds DEPTH characters
- char_count  out  CW  characters currently buffered
- start  in  1  begin transmission
- busy  out  1  high in SEND or WAIT
- ready_o  out  1  to AEC ready; high only with the first character
- ascii_o  out  8  to AEC ascii_in
- valid_i  in  1  from AEC valid
- result_i  in  7  from AEC result
- done  out  1  one-cycle pulse at end of transaction
- result_o  out  7  captured result; held until next done
- timeout  out  1  set with done if valid_i never arrived; held until next done

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset all outputs are 0, char_count=0, state=IDLE.
- All AEC-side outputs are registered.

States:
- IDLE:
  - wr_en with !buf_full writes buf[char_count], then char_count++.
  - wr_en while full is dropped.
  - start with char_count>0 moves to SEND and resets the index to 0.
  - start with char_count==0 is ignored.
  - If start and wr_en arrive in the same cycle, start wins and the write is dropped.
- SEND:
  - If start is accepted at edge T, then at cycle T+1 ready_o=1 and ascii_o=buf[0].
  - Cycle T+1+k drives buf[k] with ready_o=0.
  - After buf[char_count-1] is driven (cycle T+char_count), go to WAIT. ascii_o returns to 0.
  - wr_en and start are ignored while busy.
- WAIT:
  - Each cycle, sample valid_i. The first cycle of WAIT is T+char_count+1.
  - On valid_i=1: result_o<=result_i, timeout<=0, go to DONE.
  - The wait counter increments each cycle. When it reaches TIMEOUT-1 without valid_i: result_o<=0, timeout<=1, go to DONE.
  - If valid_i arrives on the final counted cycle, valid wins.
- DONE: done=1 for exactly one cycle, char_count cleared to 0, return to IDLE.

Other rules:
- valid_i outside WAIT is ignored; result_o is not updated.
- busy is high exactly when state is SEND or WAIT.
- Reset in the middle of SEND or WAIT aborts immediately: outputs return to reset values and the buffer is emptied.
- ready_o is never high on two consecutive cycles.
- A new ready pulse cannot occur earlier than 2 cycles after done.

Optional Feature:
- Macro: AEC_TX_AUTO_EQ_EN.
- When defined: if the last buffered character is not '=' (8'h3D), SEND adds one extra cycle driving '=' before WAIT. Total SEND length is char_count+1 cycles in that case. buf_full is asserted at DEPTH-1 so that space for '=' is reserved.
- When undefined: exactly char_count characters are sent, verbatim.

Decomposition:
- Package aec_pkg holds:
  - ASCII constants: ASCII_EQ=8'h3D, ASCII_PLUS, ASCII_MINUS, ASCII_MUL, ASCII_LPAR, ASCII_RPAR, ASCII_0.
  - RESULT_W=7.
  - The typedef enum tx_state_t {IDLE, SEND, WAIT, DONE}.
- One sub-module, aec_char_buf. It holds the DEPTH x 8 storage, write pointer, count and full flag, with a combinational read at an index.
- The FSM, wait counter and output registers stay in aec_expr_tx.

Test Plan:
- Write "3+4=" (4 chars) then pulse start; bench AEC model asserts valid 1 cycle after '=' with result 7 -> ready_o=1 only on the '3' cycle; chars 8'h33,8'h2B,8'h34,8'h3D on consecutive cycles; done pulse; result_o=7; timeout=0.
- Write "9*9=" and the model never asserts valid -> done exactly TIMEOUT cycles after the first WAIT cycle; timeout=1; result_o=0.
- Write 17 chars with DEPTH=16 -> buf_full after 16; char_count stays 16; 17th character not transmitted.
- Assert rst in the middle of SEND after 2 chars of "12+5=" -> next cycle ready_o=0, ascii_o=0, busy=0, char_count=0; a subsequent "1+1=" transaction completes with result 2.
- With AEC_TX_AUTO_EQ_EN defined, write "6-2" -> 4 characters sent, the last being 8'h3D; result 4 captured. Without the macro, only 3 characters are sent.
- Test spurious and edge-case inputs:
  - Pulse valid_i=1 with result 55 during IDLE and during SEND -> result_o unchanged, no done.
  - start with an empty buffer -> no activity.

Source files
------------

// File: rtl/aec_pkg.sv
// Shared constants and state type for the AEC ascii-stream transmitter.
package aec_pkg;

  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_MUL   = 8'h2A;
  localparam logic [7:0] ASCII_LPAR  = 8'h28;
  localparam logic [7:0] ASCII_RPAR  = 8'h29;
  localparam logic [7:0] ASCII_0     = 8'h30;

  localparam int RESULT_W = 7;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} tx_state_t;

endpackage

// File: rtl/aec_char_buf.sv
// Character buffer: DEPTH x 8 storage filled in order, count doubles as write pointer.
module aec_char_buf #(
  parameter int DEPTH   = 16,
  parameter int FULL_AT = DEPTH,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clear,
  input  logic [CW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_reg [DEPTH];
  logic [CW-1:0] count_reg;
  logic          do_write;

  assign full     = (count_reg >= CW'(FULL_AT));
  assign do_write = wr_en && !full;
  assign count    = count_reg;

  always_ff @(posedge clk) begin
    if (do_write) mem_reg[count_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear)  count_reg <= '0;
    else if (do_write) count_reg <= count_reg + 1'b1;
  end

  // The index one past the last entry is read while SEND finishes; return 0 there.
  assign rd_data = (rd_idx < CW'(DEPTH)) ? mem_reg[rd_idx[AW-1:0]] : 8'h00;

endmodule

// File: rtl/aec_expr_tx.sv
// Buffers an ASCII expression, streams it to AEC and captures the result or a timeout.
// Optional AEC_TX_AUTO_EQ_EN: append '=' when the buffered expression lacks one.
module aec_expr_tx
  import aec_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                buf_full,
  output logic [CW-1:0]       char_count,
  input  logic                start,
  output logic                busy,
  output logic                ready_o,
  output logic [7:0]          ascii_o,
  input  logic                valid_i,
  input  logic [RESULT_W-1:0] result_i,
  output logic                done,
  output logic [RESULT_W-1:0] result_o,
  output logic                timeout
);

`ifdef AEC_TX_AUTO_EQ_EN
  localparam int FULL_AT = DEPTH - 1;
`else
  localparam int FULL_AT = DEPTH;
`endif
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  tx_state_t     state_reg;
  logic [CW-1:0] idx_reg;
  logic [TW-1:0] wait_cnt_reg;
  logic [CW-1:0] rd_idx;
  logic [7:0]    rd_data;
  logic          buf_wr;
  logic          buf_clear;

  // start takes priority over a same-cycle write, and nothing is written while busy.
  assign buf_wr    = (state_reg == IDLE) && wr_en && !start;
  assign buf_clear = (state_reg == DONE);
  assign rd_idx    = (state_reg == SEND) ? idx_reg : '0;
  assign busy      = (state_reg == SEND) || (state_reg == WAIT);

  aec_char_buf #(
    .DEPTH   (DEPTH),
    .FULL_AT (FULL_AT),
    .CW      (CW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data (wr_data),
    .clear   (buf_clear),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .count   (char_count),
    .full    (buf_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      ready_o      <= 1'b0;
      ascii_o      <= 8'h00;
      done         <= 1'b0;
      result_o     <= '0;
      timeout      <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      done    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && (char_count != '0)) begin
            state_reg <= SEND;
            ready_o   <= 1'b1;
            ascii_o   <= rd_data;
            idx_reg   <= CW'(1);
          end
        end
        SEND: begin
          if (idx_reg < char_count) begin
            ascii_o <= rd_data;
            idx_reg <= idx_reg + 1'b1;
          end
`ifdef AEC_TX_AUTO_EQ_EN
          // ascii_o still holds the last buffered character here.
          else if (ascii_o != ASCII_EQ) begin
            ascii_o <= ASCII_EQ;
          end
`endif
          else begin
            ascii_o      <= 8'h00;
            wait_cnt_reg <= '0;
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          if (valid_i) begin
            result_o  <= result_i;
            timeout   <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
            result_o  <= '0;
            timeout   <= 1'b1;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aec_expr_tx.sv
// Scoreboard bench for aec_expr_tx: stimulus queues expected characters and results, a monitor pops them.
module tb_aec_expr_tx;
  import aec_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int CW      = 5;
`ifdef AEC_TX_AUTO_EQ_EN
  localparam int CAP  = DEPTH - 1;
  localparam bit AUTO = 1'b1;
`else
  localparam int CAP  = DEPTH;
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    logic [7:0] ch;
    logic       rdy;
    int         cyc;
  } chr_t;

  typedef struct {
    logic [6:0] res;
    logic       to;
    int         cyc;
  } don_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          buf_full;
  logic [CW-1:0] char_count;
  logic          start;
  logic          busy;
  logic          ready_o;
  logic [7:0]    ascii_o;
  logic          valid_i;
  logic [6:0]    result_i;
  logic          done;
  logic [6:0]    result_o;
  logic          timeout;

  logic       model_en;
  logic       model_valid;
  logic [6:0] model_result;
  logic       spur_valid;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  logic ready_prev = 1'b0;
  chr_t exp_chr[$];
  don_t exp_don[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign valid_i  = model_valid | spur_valid;
  assign result_i = spur_valid ? 7'd55 : model_result;

  aec_expr_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .buf_full   (buf_full),
    .char_count (char_count),
    .start      (start),
    .busy       (busy),
    .ready_o    (ready_o),
    .ascii_o    (ascii_o),
    .valid_i    (valid_i),
    .result_i   (result_i),
    .done       (done),
    .result_o   (result_o),
    .timeout    (timeout)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // AEC model: answers one cycle after it sees '=' on the stream.
  initial begin
    model_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && ascii_o == ASCII_EQ) begin
        @(negedge clk);
        model_valid = 1'b1;
        @(negedge clk);
        model_valid = 1'b0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    chr_t c;
    don_t d;
    if (ready_o || ascii_o != 8'h00) begin
      if (exp_chr.size() == 0) begin
        check("unexpected_char", int'(ascii_o), 0);
      end else begin
        c = exp_chr.pop_front();
        check("char", int'(ascii_o), int'(c.ch));
        check("ready", int'(ready_o), int'(c.rdy));
        check("char_cycle", cyc, c.cyc);
        $display("char %s ready=%0d cycle=%0d", string'(ascii_o), ready_o, cyc);
      end
    end
    if (ready_o) check("ready_back_to_back", int'(ready_prev), 0);
    ready_prev <= ready_o;
    if (done) begin
      if (exp_don.size() == 0) begin
        check("unexpected_done", int'(done), 0);
      end else begin
        d = exp_don.pop_front();
        check("result", int'(result_o), int'(d.res));
        check("timeout", int'(timeout), int'(d.to));
        check("done_cycle", cyc, d.cyc);
        $display("done result=%0d timeout=%0d cycle=%0d", result_o, timeout, cyc);
      end
      done_seen <= done_seen + 1;
    end
  end

  task automatic write_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      wr_en   = 1'b1;
      wr_data = s[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic transmit(input string s, input int n, input int res, input bit to, input bit want_done);
    int   base;
    chr_t c;
    don_t d;
    base = cyc;
    for (int k = 0; k < n; k++) begin
      c.ch  = s[k];
      c.rdy = (k == 0);
      c.cyc = base + 1 + k;
      exp_chr.push_back(c);
    end
    if (want_done) begin
      d.res = 7'(res);
      d.to  = to;
      d.cyc = to ? base + n + 1 + TIMEOUT : base + n + 2;
      exp_don.push_back(d);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int seen;
    seen = done_seen;
    for (int i = 0; i < 200; i++) begin
      if (done_seen != seen) break;
      @(negedge clk);
    end
    check(name, int'(done_seen != seen), 1);
    @(negedge clk);
    check("count_cleared", int'(char_count), 0);
    check("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    string full_s;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0;
    model_en = 1'b0; model_result = 7'd0; spur_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready_o), 0);
    check("rst_ascii", int'(ascii_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result_o), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_count", int'(char_count), 0);
    check("rst_full", int'(buf_full), 0);
    rst = 1'b0;
    @(negedge clk);

    // Spurious valid in IDLE, then start with an empty buffer
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    @(negedge clk);
    check("spur_idle_result", int'(result_o), 0);
    check("spur_idle_done", done_seen, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("empty_start_busy", int'(busy), 0);
    @(negedge clk);
    check("empty_start_busy2", int'(busy), 0);

    // "3+4=" with a spurious valid during SEND
    write_str("3+4=");
    check("count_3p4", int'(char_count), 4);
    model_en = 1'b1;
    model_result = 7'd7;
    transmit("3+4=", 4, 7, 1'b0, 1'b1);
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    wait_done("done_3p4");
    check("hold_result_3p4", int'(result_o), 7);

    // "9*9=" with no answer -> timeout
    write_str("9*9=");
    model_en = 1'b0;
    transmit("9*9=", 4, 0, 1'b1, 1'b1);
    wait_done("done_timeout");
    check("hold_timeout", int'(timeout), 1);

    // 17 characters into a DEPTH-16 buffer
    full_s = "1+2+3+4+5+6+7+8=9";
    write_str(full_s.substr(0, CAP - 2));
    check("not_full_yet", int'(buf_full), 0);
    write_str(full_s.substr(CAP - 1, 16));
    check("full", int'(buf_full), 1);
    check("count_full", int'(char_count), CAP);
    model_en = 1'b1;
    model_result = 7'd36;
    transmit("1+2+3+4+5+6+7+8=", 16, 36, 1'b0, 1'b1);
    wait_done("done_full");

    // Reset after two characters of "12+5="
    write_str("12+5=");
    transmit("12+5=", 2, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", int'(ready_o), 0);
    check("abort_ascii", int'(ascii_o), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_count", int'(char_count), 0);
    check("abort_result", int'(result_o), 0);
    rst = 1'b0;
    @(negedge clk);
    write_str("1+1=");
    model_result = 7'd2;
    transmit("1+1=", 4, 2, 1'b0, 1'b1);
    wait_done("done_1p1");

    // "6-2" without '='
    write_str("6-2");
    model_result = 7'd4;
    if (AUTO) transmit("6-2=", 4, 4, 1'b0, 1'b1);
    else      transmit("6-2=", 3, 0, 1'b1, 1'b1);
    wait_done("done_6m2");
    check("result_6m2", int'(result_o), AUTO ? 4 : 0);

    // Spurious valid after completion leaves the held result alone
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_end_result", int'(result_o), AUTO ? 4 : 0);
    check("chars_left", exp_chr.size(), 0);
    check("dones_left", exp_don.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
